// File: rtl/rst_seq.sv
// rst_seq: releases C_STAGE_NUM reset domains in order, with a hold time, inter-stage gaps and optional ack waits.
// Optional feature: define RST_SEQ_ACK_LOSS_EN to restart the sequence when a masked ack drops while in DONE.
module rst_seq #(
   parameter int unsigned C_STAGE_NUM    = 4,
   parameter int unsigned C_HOLD_CLK_NUM = 16,
   parameter int unsigned C_GAP_CLK_NUM  = 8,
   parameter logic [7:0]  C_ACK_MASK     = 8'h00,
   parameter int unsigned C_ACK_TIMEOUT  = 65535
) (
   input  logic                   SYS_CLK_I,
   input  logic                   SYS_RSTN_I,
   input  logic                   RST_REQ_I,
   input  logic [C_STAGE_NUM-1:0] STAGE_ACK_I,
   output logic [C_STAGE_NUM-1:0] STAGE_RSTN_O,
   output logic                   SEQ_BUSY_O,
   output logic                   SEQ_DONE_O,
   output logic [2:0]             STAGE_IDX_O,
   output logic                   TIMEOUT_O,
   output logic                   ACK_LOST_O
);

   typedef enum logic [2:0] {S_HOLD, S_REL, S_WAIT_ACK, S_GAP, S_DONE} state_t;

   localparam logic [C_STAGE_NUM-1:0] MASK_N    = C_ACK_MASK[C_STAGE_NUM-1:0];
   localparam logic [19:0]            HOLD_LAST = 20'(C_HOLD_CLK_NUM - 1);
   localparam logic [19:0]            GAP_LAST  = 20'((C_GAP_CLK_NUM == 0) ? 0 : C_GAP_CLK_NUM - 1);
   localparam logic [19:0]            TO_LAST   = 20'(C_ACK_TIMEOUT - 1);
   localparam logic [2:0]             IDX_LAST  = 3'(C_STAGE_NUM - 1);

   state_t                   state_q;
   logic [19:0]              cnt_q;
   logic [19:0]              cnt_d;
   logic [2:0]               idx_q;
   logic [C_STAGE_NUM-1:0]   rstn_q;
   logic                     busy_q;
   logic                     done_q;
   logic                     timeout_q;
   logic                     ack_lost_q;
   logic [C_STAGE_NUM-1:0]   ack_s1_q;
   logic [C_STAGE_NUM-1:0]   ack_s2_q;
   logic [C_STAGE_NUM-1:0]   sel_d;
   logic                     ack_cur_d;
   logic                     mask_cur_d;
   logic                     ack_loss_d;

   assign cnt_d = cnt_q + 20'd1;

   always_comb begin
      sel_d = '0;
      for (int i = 0; i < int'(C_STAGE_NUM); i++) begin
         sel_d[i] = (idx_q == 3'(i));
      end
   end

   assign ack_cur_d  = |(ack_s2_q & sel_d);
   assign mask_cur_d = |(MASK_N & sel_d);

`ifdef RST_SEQ_ACK_LOSS_EN
   assign ack_loss_d = (state_q == S_DONE) && ((ack_s2_q & MASK_N) != MASK_N);
`else
   assign ack_loss_d = 1'b0;
`endif

   // Two-flop synchroniser for the possibly asynchronous per-stage acks.
   always_ff @(posedge SYS_CLK_I) begin
      if (!SYS_RSTN_I) begin
         ack_s1_q <= '0;
         ack_s2_q <= '0;
      end else begin
         ack_s1_q <= STAGE_ACK_I;
         ack_s2_q <= ack_s1_q;
      end
   end

   always_ff @(posedge SYS_CLK_I) begin
      if (!SYS_RSTN_I) begin
         state_q    <= S_HOLD;
         cnt_q      <= '0;
         idx_q      <= '0;
         rstn_q     <= '0;
         busy_q     <= 1'b1;
         done_q     <= 1'b0;
         timeout_q  <= 1'b0;
         ack_lost_q <= 1'b0;
      end else if (RST_REQ_I || ack_loss_d) begin
         state_q    <= S_HOLD;
         cnt_q      <= '0;
         idx_q      <= '0;
         rstn_q     <= '0;
         busy_q     <= 1'b1;
         done_q     <= 1'b0;
         timeout_q  <= 1'b0;
         ack_lost_q <= ack_loss_d;
      end else begin
         case (state_q)
            S_HOLD: begin
               busy_q <= 1'b1;
               done_q <= 1'b0;
               if (cnt_q == HOLD_LAST) begin
                  state_q <= S_REL;
                  cnt_q   <= '0;
                  idx_q   <= '0;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            // The last stage has no successor, so it skips the gap.
            S_REL: begin
               rstn_q <= rstn_q | sel_d;
               cnt_q  <= '0;
               if (mask_cur_d)
                  state_q <= S_WAIT_ACK;
               else if (idx_q == IDX_LAST)
                  state_q <= S_DONE;
               else
                  state_q <= S_GAP;
            end
            S_WAIT_ACK: begin
               if (ack_cur_d) begin
                  cnt_q   <= '0;
                  state_q <= (idx_q == IDX_LAST) ? S_DONE : S_GAP;
               end else if (cnt_q == TO_LAST) begin
                  timeout_q <= 1'b1;
                  rstn_q    <= '0;
                  cnt_q     <= '0;
                  idx_q     <= '0;
                  state_q   <= S_HOLD;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            S_GAP: begin
               if (cnt_q == GAP_LAST) begin
                  cnt_q   <= '0;
                  idx_q   <= idx_q + 3'd1;
                  state_q <= S_REL;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            S_DONE: begin
               rstn_q <= '1;
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end
            default: state_q <= S_HOLD;
         endcase
      end
   end

   assign STAGE_RSTN_O = rstn_q;
   assign SEQ_BUSY_O   = busy_q;
   assign SEQ_DONE_O   = done_q;
   assign STAGE_IDX_O  = idx_q;
   assign TIMEOUT_O    = timeout_q;
   assign ACK_LOST_O   = ack_lost_q;

endmodule
